// File: rtl/bitmanip_clmul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitmanip_clmul_iter: iterative carry-less multiply (clmul/h/r),      |
// | STEP bits of B per cycle.                  Rev 1.0                   |
// +----------------------------------------------------------------------+
module bitmanip_clmul_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Funct3,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   p_d;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_d;
  logic [2:0]           f3_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;

  // a_q is pre-shifted by cnt*STEP and b_q pre-shifted right, so only the
  // low STEP bits of B and small fixed shifts of A are needed each cycle.
  always_comb begin
    p_d = p_q;
    for (int i = 0; i < STEP; i++) begin
      if (b_q[i]) begin
        p_d = p_d ^ (a_q << i);
      end
    end
  end

  always_comb begin
    case (f3_q)
      3'b001:  result_d = p_d[WIDTH-1:0];
      3'b011:  result_d = p_d[2*WIDTH-1:WIDTH];
      3'b010:  result_d = p_d[2*WIDTH-2:WIDTH-1];
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      f3_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (Flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          p_q   <= p_d;
          a_q   <= a_q << STEP;
          b_q   <= b_q >> STEP;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q  <= DONE;
            result_q <= result_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (Start) begin
            state_q <= RUN;
            a_q     <= {{WIDTH{1'b0}}, A};
            b_q     <= B;
            f3_q    <= Funct3;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule
`default_nettype wire

// File: doc/bitmanip_clmul_iter.md
BITMANIP_CLMUL_ITER -- requirements
Module: bitmanip_clmul_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter STEP, default 4, giving B bits processed per cycle; legal values are 1, 2, 4, 8, and 16, with WIDTH % STEP == 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit: request a new operation, sampled on the clk rising edge.
REQ-006 The block SHALL have port Flush, input, 1 bit: synchronous abort of any operation in flight.
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: operands, sampled only when Start is accepted.
REQ-008 The block SHALL have port Funct3, input, 3 bits: operation select (001 clmul, 011 clmulh, 010 clmulr), sampled with A and B.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while an operation is iterating.
REQ-010 The block SHALL have port Done, output, 1 bit: a one-cycle pulse marking Result valid.
REQ-011 The block SHALL have port Result, output, WIDTH bits: registered result, held until the next Done.

Function
REQ-012 Iteration count N SHALL equal WIDTH/STEP.
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 Start SHALL be accepted only in IDLE or DONE with Flush low.
- On acceptance, the block latches A, B and Funct3, clears the 2*WIDTH-bit accumulator P, zeroes the step counter, and enters RUN.
REQ-015 Each RUN cycle SHALL process STEP bits of B:
- For each bit i of B[cnt*STEP +: STEP] that is set, P ^= zero-extended A << (cnt*STEP + i).
- The counter then increments.
REQ-016 RUN SHALL last exactly N cycles, then transition to DONE.
REQ-017 On the RUN-to-DONE edge, Result SHALL load:
- P[WIDTH-1:0] for clmul;
- P[2*WIDTH-1:WIDTH] for clmulh;
- P[2*WIDTH-2:WIDTH-1] for clmulr;
- all zeros for any other Funct3 value.
REQ-018 Done SHALL be high for exactly the one cycle spent in DONE.
- Latency: Start accepted at edge k means Done is high in the cycle following edge k+N.
REQ-019 DONE SHALL go to RUN if Start is accepted, otherwise to IDLE, allowing back-to-back operations with no idle cycle.
REQ-020 Busy SHALL be high exactly in RUN.
REQ-021 Start asserted while in RUN SHALL be ignored: no operand latch and no effect on the current operation.
REQ-022 Flush SHALL have highest priority. Flush high at any edge forces IDLE, clears the counter, suppresses Done, and leaves Result unchanged.
- Flush and Start together: Start is dropped.
REQ-023 Operand changes on A, B or Funct3 after acceptance SHALL have no effect on the operation in flight.
REQ-024 The counter SHALL be ceil(log2(N))+1 bits wide and SHALL NOT wrap within an operation.
REQ-025 Carry-less arithmetic SHALL use XOR only, with no carries and no sign extension; W-form variants do not exist.

Reset
REQ-026 With reset low, asynchronously: state = IDLE, Busy = 0, Done = 0, Result = 0, P = 0, counter = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no Done pulse. The first Start after reset deasserts is accepted normally.
REQ-028 Reset deassertion SHALL be the only exit from reset. No output toggles until the first accepted Start.

Verification
REQ-029 The bench SHALL cover the following directed scenarios at WIDTH=32, STEP=4 (N=8):
- Basic clmul: A=0x00000003, B=0x00000003, Funct3=001, Start at edge k -> Busy high for 8 cycles; Done high in the cycle after edge k+8; Result=0x00000005.
- clmulh and clmulr: A=B=0x80000000. Funct3=011 -> Result=0x40000000. Funct3=010 -> Result=0x80000000.
- Start ignored while busy: A=0xFFFFFFFF, B=0x1 accepted; Start pulsed at cycle 3 with A=0x0 -> Result=0xFFFFFFFF; exactly one Done pulse.
- Flush mid-operation: Flush at cycle 4 of RUN -> IDLE next cycle, no Done, Result keeps its previous value. A following Start with A=0x2, B=0x2, clmul -> Result=0x4.
- Back-to-back: Start held in the DONE cycle with new operands -> Busy high the next cycle; second Done exactly 9 cycles after the first.
- Reset mid-run: reset low at cycle 5 of RUN -> all outputs 0 immediately, no Done. Also run random A/B at WIDTH=64, STEP=1/8/16 against a software clmul model for all three Funct3 values.
